fixed_sqrt: RTL and testbench

Iterative fixed-point square-root unit sitting directly downstream of the leading-set-bit seed stage. Takes an unsigned Q(WIDTH-FRAC).FRAC radicand plus that stage's seed location and produces an unsigned Q((WIDTH-FRAC)/2).FRAC root using digit-by-digit (restoring) evaluation, one root bit per cycle. The seed skips leading root bits that are provably zero, shortening latency for small radicands.

---
 rtl/fixed_sqrt.sv | 126 ++++++++++++
 tb/tb_fixed_sqrt.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/fixed_sqrt.sv
// Iterative restoring fixed-point square root, one root bit per cycle.
// Define FIXED_SQRT_SEED_EN to start at the seeded top bit instead of ROOT_W-1.
module fixed_sqrt #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned FRAC  = 4,
    localparam int unsigned ROOT_W = (WIDTH + FRAC) / 2
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              start,
    input  logic [WIDTH-1:0]  radicand,
    input  logic [5:0]        seed_loc,
    output logic              busy,
    output logic              valid,
    output logic [ROOT_W-1:0] root,
    output logic              exact
);

    localparam int unsigned R_W = WIDTH + FRAC;
    localparam int unsigned T_W = R_W + 1;
    localparam int unsigned B_W = (ROOT_W > 1) ? $clog2(ROOT_W) : 1;
    localparam int unsigned IW  = (WIDTH - FRAC) / 2;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state_q, state_d;
    logic [R_W-1:0]    r_q, r_d;
    logic [ROOT_W-1:0] acc_q, acc_d;
    logic [R_W-1:0]    sq_q, sq_d;
    logic [B_W-1:0]    b_q, b_d;
    logic              busy_d, valid_d, exact_d;
    logic [ROOT_W-1:0] root_d;
    logic [ROOT_W-1:0] trial;
    logic [T_W-1:0]    trial_sq;
    logic [B_W-1:0]    b_init;
    logic              unused_seed;

`ifdef FIXED_SQRT_SEED_EN
    int unsigned seed_k;

    // Leading root bits above FRAC+k are known zero, so skip them.
    always_comb begin
        seed_k = 32'(seed_loc[5:4]);
        if (seed_k > IW - 1) begin
            seed_k = IW - 1;
        end
        b_init = B_W'(FRAC + seed_k);
    end
    assign unused_seed = ^seed_loc[3:0];
`else
    assign b_init      = B_W'(ROOT_W - 1);
    assign unused_seed = ^seed_loc;
`endif

    // trial^2 = acc^2 + acc*2^(b+1) + 2^(2b); acc has no bits at or below b.
    always_comb begin
        state_d  = state_q;
        r_d      = r_q;
        acc_d    = acc_q;
        sq_d     = sq_q;
        b_d      = b_q;
        root_d   = root;
        exact_d  = exact;
        trial    = acc_q | (ROOT_W'(1) << b_q);
        trial_sq = T_W'(sq_q) + (T_W'({acc_q, 1'b0}) << b_q) + (T_W'(1) << {b_q, 1'b0});

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CALC;
                    r_d     = R_W'({radicand, {FRAC{1'b0}}});
                    acc_d   = '0;
                    sq_d    = '0;
                    b_d     = b_init;
                end
            end
            CALC: begin
                if (trial_sq <= T_W'(r_q)) begin
                    acc_d = trial;
                    sq_d  = R_W'(trial_sq);
                end
                if (b_q == '0) begin
                    state_d = DONE;
                    root_d  = acc_d;
                    exact_d = (sq_d == r_q);
                end else begin
                    b_d = b_q - B_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d  = (state_d != IDLE);
        valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst_) begin
            state_q <= IDLE;
            r_q     <= '0;
            acc_q   <= '0;
            sq_q    <= '0;
            b_q     <= '0;
            busy    <= 1'b0;
            valid   <= 1'b0;
            root    <= '0;
            exact   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            acc_q   <= acc_d;
            sq_q    <= sq_d;
            b_q     <= b_d;
            busy    <= busy_d;
            valid   <= valid_d;
            root    <= root_d;
            exact   <= exact_d;
        end
    end

endmodule

// File: tb/tb_fixed_sqrt.sv
// Directed bench for fixed_sqrt (WIDTH=12, FRAC=4); latencies follow FIXED_SQRT_SEED_EN.
module tb_fixed_sqrt;

    logic        clk = 1'b0;
    logic        rst_;
    logic        start;
    logic [11:0] radicand;
    logic [5:0]  seed_loc;
    logic        busy;
    logic        valid;
    logic [7:0]  root;
    logic        exact;

    int tests = 0;
    int fails = 0;
    int lat;
    int nvalid;
    logic [7:0] got_root;

`ifdef FIXED_SQRT_SEED_EN
    localparam bit SEED = 1'b1;
`else
    localparam bit SEED = 1'b0;
`endif

    fixed_sqrt #(.WIDTH(12), .FRAC(4)) dut (
        .clk      (clk),
        .rst_     (rst_),
        .start    (start),
        .radicand (radicand),
        .seed_loc (seed_loc),
        .busy     (busy),
        .valid    (valid),
        .root     (root),
        .exact    (exact)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one operation and check result, latency and the valid/busy handshake.
    task automatic run_op(input string tag, input logic [11:0] rad, input logic [5:0] seed,
                          input logic [7:0] er, input logic ee, input int elat);
        @(negedge clk);
        start    = 1'b1;
        radicand = rad;
        seed_loc = seed;
        @(posedge clk);
        #1;
        start    = 1'b0;
        radicand = ~rad;
        seed_loc = 6'h00;
        lat = 0;
        for (int j = 1; j <= 40; j++) begin
            @(negedge clk);
            if (valid) begin
                lat = j;
                break;
            end
        end
        check({tag, "_lat"},   32'(lat),   32'(elat));
        check({tag, "_root"},  32'(root),  32'(er));
        check({tag, "_exact"}, 32'(exact), 32'(ee));
        check({tag, "_busy"},  32'(busy),  32'd1);
        @(negedge clk);
        check({tag, "_vpulse"}, 32'(valid), 32'd0);
        check({tag, "_bfall"},  32'(busy),  32'd0);
        check({tag, "_hold"},   32'(root),  32'(er));
    endtask

    initial begin
        rst_     = 1'b1;
        start    = 1'b0;
        radicand = '0;
        seed_loc = '0;
        repeat (2) @(negedge clk);
        rst_ = 1'b0;
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_root",  32'(root),  32'd0);
        check("rst_exact", 32'(exact), 32'd0);

        run_op("r4_0",   12'h040, 6'h10, 8'h20, 1'b1, SEED ? 7 : 9);
        run_op("r2_0",   12'h020, 6'h10, 8'h16, 1'b0, SEED ? 7 : 9);
        run_op("rmax",   12'hFFF, 6'h30, 8'hFF, 1'b0, 9);
        run_op("r0_25",  12'h004, 6'h00, 8'h08, 1'b1, SEED ? 6 : 9);
        run_op("rzero",  12'h000, 6'h00, 8'h00, 1'b1, SEED ? 6 : 9);

        // start held during CALC with other operands must be ignored
        @(negedge clk);
        start    = 1'b1;
        radicand = 12'h040;
        seed_loc = 6'h10;
        @(posedge clk);
        #1;
        radicand = 12'hFFF;
        seed_loc = 6'h30;
        nvalid = 0;
        lat = 0;
        got_root = '0;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            if (valid) begin
                nvalid++;
                if (lat == 0) lat = j;
                got_root = root;
            end
            start = busy && !valid;
        end
        start = 1'b0;
        check("busy_ign_nvalid", 32'(nvalid),   32'd1);
        check("busy_ign_lat",    32'(lat),      SEED ? 32'd7 : 32'd9);
        check("busy_ign_root",   32'(got_root), 32'h20);
        check("busy_ign_exact",  32'(exact),    32'd1);
        check("busy_ign_idle",   32'(busy),     32'd0);

        // reset during CALC abandons the operation
        @(negedge clk);
        start    = 1'b1;
        radicand = 12'h020;
        seed_loc = 6'h10;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_ = 1'b1;
        @(negedge clk);
        rst_ = 1'b0;
        check("mid_rst_busy",  32'(busy),  32'd0);
        check("mid_rst_valid", 32'(valid), 32'd0);
        check("mid_rst_root",  32'(root),  32'd0);
        check("mid_rst_exact", 32'(exact), 32'd0);
        nvalid = 0;
        for (int j = 0; j < 15; j++) begin
            @(negedge clk);
            if (valid) nvalid++;
        end
        check("mid_rst_novalid", 32'(nvalid), 32'd0);

        run_op("after_rst", 12'h004, 6'h00, 8'h08, 1'b1, SEED ? 6 : 9);
        run_op("r9_0",      12'h090, 6'h10, 8'h30, 1'b1, SEED ? 7 : 9);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
